level_tile_arbiter: RTL and testbench
=====================================

# level_tile_arbiter

Sequencer and arbiter for the single-read-port level tile RAM (`level_ram`, 201×30 tiles, 5-bit tile codes). It converts (column,row) tile coordinates into RAM addresses. It shares the read port between the background renderer (fixed priority) and the collision unit, which issues a 4-corner probe sequence. It also drives the RAM write port for tile updates from game logic.

## Interface
- MAP_W, 201, tiles per row
- MAP_H, 30, rows
- TILE_W, 5, tile code width
- ADDR_W, 19, RAM address width
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- ram_read_address  out  ADDR_W  registered RAM read address
- ram_write_address  out  ADDR_W  registered RAM write address
- ram_data_In  out  TILE_W  registered write data
- ram_we  out  1  registered write enable
- ram_data_Out  in  TILE_W  RAM read data, valid one cycle after the address edge
- rd_req  in  1  renderer lookup request, sampled every cycle
- rd_col / rd_row  in  8 / 5  renderer tile coordinate
- rd_valid  out  1  renderer result valid
- rd_tile  out  TILE_W  renderer tile code
- col_start  in  1  start a collision probe
- col_col / col_row  in  8 / 5  top-left tile of the 2×2 probe box
- col_busy  out  1  probe in progress
- col_done  out  1  one-cycle pulse when col_mask is final
- col_mask  out  4  solid flags: bit0 (c,r), bit1 (c+1,r), bit2 (c,r+1), bit3 (c+1,r+1)
- wr_req  in  1  tile write request
- wr_col / wr_row / wr_tile  in  8 / 5 / TILE_W  write target and data
- wr_ack  out  1  one-cycle write acknowledge

## Operation
- Address: `addr = row*MAP_W + col`, computed unsigned in 13 bits and zero-extended to ADDR_W. (col 10, row 2) → 412. (200, 29) → 6029.
- Out of range is col ≥ MAP_W or row ≥ MAP_H.
  - Reads: no RAM access, the result is forced.
  - Renderer: tile 0.
  - Collision: solid.
  - Writes: acked, ram_we stays low.
- Solid means tile code ≠ 0.
- Read arbitration, fixed priority:
  - rd_req always wins and the renderer is never stalled.
  - The collision FSM issues a probe only in a cycle with rd_req low.
- Tag pipeline, 2 stages, each holding {valid, owner, probe index, forced flag, forced value}. Stage 2 routes ram_data_Out (or the forced value) to the owner.
- Collision FSM:
  - IDLE: col_start latches the coordinates, clears col_mask, sets idx=0, goes to PROBE. col_start while not IDLE is ignored.
  - PROBE: probe idx is issued when not preempted, then idx increments. After idx 3 is issued, go to DRAIN.
  - DRAIN: wait until the idx-3 result retires. That cycle updates mask bit 3 and goes to DONE.
  - DONE: col_done=1 for one cycle, col_busy=0, then return to IDLE.
  - col_busy is high in PROBE and DRAIN.
  - col_mask bits update as each result retires. col_mask holds its value until the next col_start.
- Write path:
  - wr_req registers ram_write_address, ram_data_In and ram_we=1 (if in range) at the next edge.
  - wr_ack pulses in that same cycle.
  - Writes are independent of reads and never stall.
  - One write is accepted per cycle.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and the tag pipeline is empty.
- Reset asserted mid-probe: the probe is abandoned, no col_done is produced, and pending rd_valid results are discarded.
- Renderer latency:
  - rd_req is high in cycle N, so ram_read_address is updated at edge N+1.
  - The RAM captures at edge N+2.
  - rd_valid=1 and rd_tile valid in cycle N+2.
  - Latency is exactly 2 cycles, fully pipelined at 1 lookup per cycle. Forced results have identical latency.
- Collision latency: with no preemption, col_start in cycle N gives col_done in cycle N+6. Each cycle of rd_req preemption adds exactly one cycle.
- Write: wr_req in cycle N gives ram_we and wr_ack in cycle N+1.
- Read and write to the same address at the same edge: the read returns the old data.
- rd_valid is never asserted for collision reads. col_mask never changes from renderer reads.

## Test plan
- Reset, then one rd_req at (10,2) with RAM[412]=7 → ram_read_address=412, rd_valid=1 and rd_tile=7 exactly 2 cycles later.
- rd_req held for 4 consecutive cycles at (0..3,0) → 4 consecutive rd_valid cycles with RAM[0..3] in order.
- col_start at (5,1) with RAM[206]=0, RAM[207]=3, RAM[407]=0, RAM[408]=1 and no rd_req → col_mask=4'b1010, col_done 6 cycles after start.
- Same probe with rd_req high for 3 cycles starting 1 cycle after col_start → col_done at +9 and renderer results undisturbed.
- col_start at (200,29) → bits 1, 2 and 3 forced solid; col_mask=4'b1110 if RAM[6029]=0. wr_req at (201,0) → wr_ack=1, ram_we=0.
- wr_req at (10,2) with tile 4 in the same cycle as rd_req at (10,2) holding 9 → ram_we with address 412 and data 4, rd_tile=9. A rd_req 1 cycle later returns 4. Reset pulsed in PROBE → no col_done and all outputs 0.

Source files
------------

// File: rtl/level_tile_arbiter.sv
// Level tile RAM sequencer: renderer lookups, 4-corner collision probes and tile writes on one RAM.
// Latency: renderer 2 cycles; probe start to col_done 6 cycles; write 1 cycle.
// Backpressure: none upstream; the renderer preempts the collision probe one cycle per rd_req cycle.
module level_tile_arbiter #(
    parameter int MAP_W  = 201,
    parameter int MAP_H  = 30,
    parameter int TILE_W = 5,
    parameter int ADDR_W = 19
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic [ADDR_W-1:0] ram_read_address,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic [TILE_W-1:0] ram_data_In,
    output logic              ram_we,
    input  logic [TILE_W-1:0] ram_data_Out,
    input  logic              rd_req,
    input  logic [7:0]        rd_col,
    input  logic [4:0]        rd_row,
    output logic              rd_valid,
    output logic [TILE_W-1:0] rd_tile,
    input  logic              col_start,
    input  logic [7:0]        col_col,
    input  logic [4:0]        col_row,
    output logic              col_busy,
    output logic              col_done,
    output logic [3:0]        col_mask,
    input  logic              wr_req,
    input  logic [7:0]        wr_col,
    input  logic [4:0]        wr_row,
    input  logic [TILE_W-1:0] wr_tile,
    output logic              wr_ack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROBE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic              vld;
        logic              own_col;
        logic [1:0]        idx;
        logic              forced;
        logic [TILE_W-1:0] fval;
    } tag_t;

    function automatic logic in_map(input logic [8:0] c, input logic [5:0] r);
        return (c < 9'(MAP_W)) && (r < 6'(MAP_H));
    endfunction

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [8:0] c, input logic [5:0] r);
        logic [12:0] a;
        a = 13'(r) * 13'(MAP_W) + 13'(c);
        return ADDR_W'(a);
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  base_col_q;
    logic [4:0]  base_row_q;
    logic [3:0]  mask_q;
    tag_t        s1_d, s1_q, s2_q;

    logic [7:0]        pcol_base;
    logic [4:0]        prow_base;
    logic [1:0]        pidx;
    logic [8:0]        probe_col, sel_col;
    logic [5:0]        probe_row, sel_row;
    logic              col_issue, rd_issue, sel_in, wr_in;
    logic              col_ret;
    logic [TILE_W-1:0] ret_dat;

    // The first corner goes out in the start cycle itself, using the live
    // coordinates, so an unpreempted probe finishes 6 cycles after col_start.
    always_comb begin
        pcol_base = base_col_q;
        prow_base = base_row_q;
        pidx      = idx_q;
        if (state_q == ST_IDLE) begin
            pcol_base = col_col;
            prow_base = col_row;
            pidx      = 2'd0;
        end
        probe_col = {1'b0, pcol_base} + 9'(pidx[0]);
        probe_row = {1'b0, prow_base} + 6'(pidx[1]);
        col_issue = !rd_req && ((state_q == ST_IDLE && col_start) || state_q == ST_PROBE);
    end

    always_comb begin
        rd_issue = rd_req || col_issue;
        sel_col  = rd_req ? {1'b0, rd_col} : probe_col;
        sel_row  = rd_req ? {1'b0, rd_row} : probe_row;
        sel_in   = in_map(sel_col, sel_row);
        s1_d     = '0;
        if (rd_issue) begin
            s1_d.vld     = 1'b1;
            s1_d.own_col = !rd_req;
            s1_d.idx     = rd_req ? 2'd0 : pidx;
            s1_d.forced  = !sel_in;
            s1_d.fval    = rd_req ? '0 : TILE_W'(1);
        end
    end

    always_comb begin
        ret_dat  = s2_q.forced ? s2_q.fval : ram_data_Out;
        rd_valid = s2_q.vld && !s2_q.own_col;
        rd_tile  = rd_valid ? ret_dat : '0;
        col_ret  = s2_q.vld && s2_q.own_col;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (col_start) begin
                    state_d = ST_PROBE;
                    idx_d   = col_issue ? 2'd1 : 2'd0;
                end
            end
            ST_PROBE: begin
                if (col_issue) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (col_ret && s2_q.idx == 2'd3) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            base_col_q <= '0;
            base_row_q <= '0;
            mask_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == ST_IDLE && col_start) begin
                base_col_q <= col_col;
                base_row_q <= col_row;
                mask_q     <= '0;
            end else if (col_ret) begin
                mask_q[s2_q.idx] <= (ret_dat != '0);
            end
        end
    end

    // Out-of-range reads leave the RAM address alone; the tag carries the answer.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ram_read_address <= '0;
            s1_q             <= '0;
            s2_q             <= '0;
        end else begin
            if (rd_issue && sel_in) begin
                ram_read_address <= tile_addr(sel_col, sel_row);
            end
            s1_q <= s1_d;
            s2_q <= s1_q;
        end
    end

    assign wr_in = in_map({1'b0, wr_col}, {1'b0, wr_row});

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ram_write_address <= '0;
            ram_data_In       <= '0;
            ram_we            <= 1'b0;
            wr_ack            <= 1'b0;
        end else begin
            wr_ack <= wr_req;
            ram_we <= wr_req && wr_in;
            if (wr_req && wr_in) begin
                ram_write_address <= tile_addr({1'b0, wr_col}, {1'b0, wr_row});
                ram_data_In       <= wr_tile;
            end
        end
    end

    assign col_busy = (state_q == ST_PROBE) || (state_q == ST_DRAIN);
    assign col_done = (state_q == ST_DONE);
    assign col_mask = mask_q;

endmodule

// File: tb/tb_level_tile_arbiter.sv
// Directed bench for level_tile_arbiter with a synchronous RAM model (read-before-write).
module tb_level_tile_arbiter;
    localparam int ADDR_W = 19;
    localparam int TILE_W = 5;

    logic              Clk, Reset;
    logic [ADDR_W-1:0] ram_read_address, ram_write_address;
    logic [TILE_W-1:0] ram_data_In, ram_data_Out;
    logic              ram_we;
    logic              rd_req, rd_valid;
    logic [7:0]        rd_col, col_col, wr_col;
    logic [4:0]        rd_row, col_row, wr_row;
    logic [TILE_W-1:0] rd_tile, wr_tile;
    logic              col_start, col_busy, col_done, wr_req, wr_ack;
    logic [3:0]        col_mask;

    logic [TILE_W-1:0] mem [0:8191];
    logic              bd_we;
    logic [12:0]       bd_addr;
    logic [TILE_W-1:0] bd_dat;

    int total = 0;
    int bad   = 0;
    int lat;
    int nev;
    logic [4:0] exp_burst [4] = '{5'd11, 5'd12, 5'd13, 5'd14};

    level_tile_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
        .ram_data_In(ram_data_In), .ram_we(ram_we), .ram_data_Out(ram_data_Out),
        .rd_req(rd_req), .rd_col(rd_col), .rd_row(rd_row),
        .rd_valid(rd_valid), .rd_tile(rd_tile),
        .col_start(col_start), .col_col(col_col), .col_row(col_row),
        .col_busy(col_busy), .col_done(col_done), .col_mask(col_mask),
        .wr_req(wr_req), .wr_col(wr_col), .wr_row(wr_row), .wr_tile(wr_tile),
        .wr_ack(wr_ack)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (bd_we) mem[bd_addr] <= bd_dat;
        if (ram_we) mem[ram_write_address[12:0]] <= ram_data_In;
        ram_data_Out <= mem[ram_read_address[12:0]];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [12:0] a, input logic [4:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_dat  = d;
        tick();
        bd_we   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_addr"}, 32'(ram_read_address), 0);
        check({tag, "_wr_addr"}, 32'(ram_write_address), 0);
        check({tag, "_wr_data"}, 32'(ram_data_In), 0);
        check({tag, "_we"}, 32'(ram_we), 0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_rd_tile"}, 32'(rd_tile), 0);
        check({tag, "_busy"}, 32'(col_busy), 0);
        check({tag, "_done"}, 32'(col_done), 0);
        check({tag, "_mask"}, 32'(col_mask), 0);
        check({tag, "_wr_ack"}, 32'(wr_ack), 0);
    endtask

    // Starts a probe; renderer lookups at (0..npre-1, 0) preempt it from the next cycle on.
    task automatic probe(input logic [7:0] c0, input logic [4:0] r0, input int npre,
                         output int lat_o);
        int ndone;
        ndone     = 0;
        col_start = 1'b1;
        col_col   = c0;
        col_row   = r0;
        tick();
        col_start = 1'b0;
        lat_o     = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c <= 10)
                check("probe_rd_valid", 32'(rd_valid), (c >= 3 && c <= npre + 2) ? 1 : 0);
            if (c >= 3 && c <= npre + 2)
                check("probe_rd_tile", 32'(rd_tile), 32'(exp_burst[c-3]));
            if (c == 1)
                check("probe_busy", 32'(col_busy), 1);
            if (col_done) begin
                ndone++;
                if (lat_o < 0) lat_o = c;
            end
            rd_req = (c <= npre);
            rd_col = 8'(c - 1);
            rd_row = 5'd0;
            tick();
        end
        rd_req = 1'b0;
        check("probe_done_pulses", 32'(ndone), 1);
    endtask

    initial begin
        Reset = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
        rd_req = 1'b0; rd_col = '0; rd_row = '0;
        col_start = 1'b0; col_col = '0; col_row = '0;
        wr_req = 1'b0; wr_col = '0; wr_row = '0; wr_tile = '0;
        tick();
        poke(13'd412, 5'd7);
        poke(13'd0, 5'd11);
        poke(13'd1, 5'd12);
        poke(13'd2, 5'd13);
        poke(13'd3, 5'd14);
        poke(13'd206, 5'd0);
        poke(13'd207, 5'd3);
        poke(13'd407, 5'd0);
        poke(13'd408, 5'd1);
        poke(13'd6029, 5'd0);
        check_all_zero("reset");
        Reset = 1'b1;
        tick();

        // Single renderer lookup at (10,2)
        rd_req = 1'b1; rd_col = 8'd10; rd_row = 5'd2;
        tick();
        rd_req = 1'b0;
        check("single_addr", 32'(ram_read_address), 412);
        check("single_early_valid", 32'(rd_valid), 0);
        tick();
        check("single_valid", 32'(rd_valid), 1);
        check("single_tile", 32'(rd_tile), 7);
        tick();
        check("single_valid_drop", 32'(rd_valid), 0);

        // Back-to-back lookups (0..3,0)
        for (int i = 0; i <= 5; i++) begin
            rd_req = (i < 4);
            rd_col = 8'(i);
            rd_row = 5'd0;
            tick();
            if (i >= 1) begin
                check("burst_valid", 32'(rd_valid), (i <= 4) ? 1 : 0);
                if (i <= 4) check("burst_tile", 32'(rd_tile), 32'(exp_burst[i-1]));
            end
        end
        rd_req = 1'b0;

        // Unpreempted probe at (5,1)
        probe(8'd5, 5'd1, 0, lat);
        check("probe_latency", 32'(lat), 6);
        check("probe_mask", 32'(col_mask), 32'b1010);
        check("probe_idle", 32'(col_busy), 0);

        // Same probe preempted for 3 cycles
        probe(8'd5, 5'd1, 3, lat);
        check("preempt_latency", 32'(lat), 9);
        check("preempt_mask", 32'(col_mask), 32'b1010);

        // Map corner: three corners out of range
        probe(8'd200, 5'd29, 0, lat);
        check("corner_latency", 32'(lat), 6);
        check("corner_mask", 32'(col_mask), 32'b1110);

        // Out-of-range write
        wr_req = 1'b1; wr_col = 8'd201; wr_row = 5'd0; wr_tile = 5'd5;
        tick();
        wr_req = 1'b0;
        check("oor_wr_ack", 32'(wr_ack), 1);
        check("oor_we", 32'(ram_we), 0);
        tick();
        check("oor_ack_drop", 32'(wr_ack), 0);

        // Write and read of (10,2) in the same cycle; read sees old data
        poke(13'd412, 5'd9);
        rd_req = 1'b1; rd_col = 8'd10; rd_row = 5'd2;
        wr_req = 1'b1; wr_col = 8'd10; wr_row = 5'd2; wr_tile = 5'd4;
        tick();
        wr_req = 1'b0;
        check("rw_we", 32'(ram_we), 1);
        check("rw_wr_addr", 32'(ram_write_address), 412);
        check("rw_wr_data", 32'(ram_data_In), 4);
        check("rw_wr_ack", 32'(wr_ack), 1);
        tick();
        rd_req = 1'b0;
        check("rw_old_valid", 32'(rd_valid), 1);
        check("rw_old_tile", 32'(rd_tile), 9);
        check("rw_we_drop", 32'(ram_we), 0);
        tick();
        check("rw_new_valid", 32'(rd_valid), 1);
        check("rw_new_tile", 32'(rd_tile), 4);
        tick();

        // Reset during a probe with a renderer lookup in flight
        col_start = 1'b1; col_col = 8'd5; col_row = 5'd1;
        tick();
        col_start = 1'b0;
        tick();
        rd_req = 1'b1; rd_col = 8'd1; rd_row = 5'd0;
        tick();
        rd_req = 1'b0;
        check("midrst_busy", 32'(col_busy), 1);
        Reset = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        tick();
        Reset = 1'b1;
        nev = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (col_done || rd_valid || col_busy) nev++;
        end
        check("midrst_quiet", 32'(nev), 0);
        check("midrst_mask", 32'(col_mask), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
